mbinit_sb_arbiter: RTL and testbench

MBINIT_SB_ARBITER -- requirements
Module: mbinit_sb_arbiter

---
 rtl/mbinit_sb_arbiter_pkg.sv | 23 ++
 rtl/mbinit_sb_rr_pick.sv | 42 ++++
 rtl/mbinit_sb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mbinit_sb_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mbinit_sb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mbinit_sb_arbiter_pkg
// Shared MBINIT definitions used by the sideband arbiter:
//   - mbinit_state_e          : arbiter FSM state encoding
//   - SB_MSG_Width            : default width of an encoded sideband message
//   - PARAM_configuration_*   : encoded MBINIT.PARAM sideband messages
// ---------------------------------------------------------------------------
package mbinit_sb_arbiter_pkg;

  localparam int SB_MSG_Width = 4;

  localparam logic [SB_MSG_Width-1:0] PARAM_configuration_req  = 4'b0001;
  localparam logic [SB_MSG_Width-1:0] PARAM_configuration_resp = 4'b0010;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } mbinit_state_e;

endpackage

// File: rtl/mbinit_sb_rr_pick.sv
// ---------------------------------------------------------------------------
// mbinit_sb_rr_pick
// Two-way round-robin selector between the TX and RX requesters. The
// pointer remembers which requester completed a transaction last; on a tie
// the other one wins. The pointer resets to "RX granted last" so TX wins
// the first tie.
// Ports:
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_req_tx/rx     : requester valids
//   i_update        : load the pointer with i_granted_tx
//   i_granted_tx    : 1 when the completed grant belonged to TX
//   o_pick_tx/rx    : combinational one-hot (or zero) pick
// ---------------------------------------------------------------------------
module mbinit_sb_rr_pick (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_tx,
  input  logic i_req_rx,
  input  logic i_update,
  input  logic i_granted_tx,
  output logic o_pick_tx,
  output logic o_pick_rx
);

  logic last_tx_q;

  always_comb begin
    o_pick_tx = i_req_tx && (!i_req_rx || !last_tx_q);
    o_pick_rx = i_req_rx && (!i_req_tx ||  last_tx_q);
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_tx_q <= 1'b0;
    end else if (i_update) begin
      last_tx_q <= i_granted_tx;
    end
  end

endmodule

// File: rtl/mbinit_sb_arbiter.sv
// ---------------------------------------------------------------------------
// mbinit_sb_arbiter
// Arbitrates the shared sideband serializer between the MBINIT TX and RX
// requesters. A winner's message is latched, issued with a one-cycle strobe,
// then the arbiter tracks the serializer busy level: rise (accepted) then
// fall (done). A missing rise within BUSY_TIMEOUT cycles aborts with a
// timeout pulse. A one-cycle GAP follows every transaction so a requester
// can drop its valid after its completion pulse.
// Every output is a flop loaded from the next-state logic.
// Ports:
//   i_clk, i_rst_n               : clock, async active-low reset
//   i_MBINIT_en                  : enable; 0 forces IDLE and clears outputs
//   i_tx_msg_valid/encoded_msg   : TX requester
//   i_rx_msg_valid/encoded_msg   : RX requester
//   i_sb_busy                    : serializer busy level
//   o_encoded_SB_msg, o_msg_valid: message + one-cycle issue strobe
//   o_tx_busy, o_rx_busy         : per-requester busy view
//   o_tx/rx_falling_edge_busy    : one-cycle completion pulses
//   o_timeout                    : one-cycle pulse when busy never rose
// BUSY_TIMEOUT must be at least 1.
// ---------------------------------------------------------------------------
module mbinit_sb_arbiter #(
  parameter int          SB_MSG_Width = mbinit_sb_arbiter_pkg::SB_MSG_Width,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_MBINIT_en,
  input  logic                    i_tx_msg_valid,
  input  logic [SB_MSG_Width-1:0] i_tx_encoded_msg,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_Width-1:0] i_rx_encoded_msg,
  input  logic                    i_sb_busy,
  output logic [SB_MSG_Width-1:0] o_encoded_SB_msg,
  output logic                    o_msg_valid,
  output logic                    o_tx_busy,
  output logic                    o_rx_busy,
  output logic                    o_tx_falling_edge_busy,
  output logic                    o_rx_falling_edge_busy,
  output logic                    o_timeout
);

  import mbinit_sb_arbiter_pkg::*;

  localparam int CNT_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  // The counter holds the number of WAIT_BUSY cycles already spent minus
  // one, so the exit edge is the one that brings the elapsed count to
  // BUSY_TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  mbinit_state_e           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    gnt_tx_q, gnt_tx_d;
  logic [SB_MSG_Width-1:0] msg_q, msg_d;

  logic                    pick_tx, pick_rx;
  logic                    ptr_update;

  logic [SB_MSG_Width-1:0] enc_d;
  logic                    valid_d, tx_busy_d, rx_busy_d;
  logic                    tx_fall_d, rx_fall_d, timeout_d;
  logic                    holds_msg, tx_owns, rx_owns;

  mbinit_sb_rr_pick u_rr_pick (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_tx     (i_tx_msg_valid),
    .i_req_rx     (i_rx_msg_valid),
    .i_update     (ptr_update),
    .i_granted_tx (gnt_tx_q),
    .o_pick_tx    (pick_tx),
    .o_pick_rx    (pick_rx)
  );

  // NOTE: every signal written in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_tx_d   = gnt_tx_q;
    msg_d      = msg_q;
    timeout_d  = 1'b0;
    tx_fall_d  = 1'b0;
    rx_fall_d  = 1'b0;
    ptr_update = 1'b0;

    if (!i_MBINIT_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Foreign traffic on the serializer blocks any new grant.
          if (!i_sb_busy && (pick_tx || pick_rx)) begin
            state_d  = ISSUE;
            gnt_tx_d = pick_tx;
            msg_d    = pick_tx ? i_tx_encoded_msg : i_rx_encoded_msg;
          end
        end
        ISSUE: begin
          state_d = WAIT_BUSY;
          cnt_d   = '0;
        end
        WAIT_BUSY: begin
          if (i_sb_busy) begin
            state_d = WAIT_DONE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = GAP;
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!i_sb_busy) begin
            state_d    = GAP;
            tx_fall_d  = gnt_tx_q;
            rx_fall_d  = !gnt_tx_q;
            ptr_update = 1'b1;
          end
        end
        GAP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output values are derived from the next state so that the registered
  // outputs line up with the state they describe.
  always_comb begin
    holds_msg = (state_d == ISSUE) || (state_d == WAIT_BUSY) ||
                (state_d == WAIT_DONE);
    tx_owns   = ((state_d == ISSUE) || (state_d == WAIT_BUSY)) && gnt_tx_d;
    rx_owns   = ((state_d == ISSUE) || (state_d == WAIT_BUSY)) && !gnt_tx_d;

    valid_d   = i_MBINIT_en && (state_d == ISSUE);
    enc_d     = (i_MBINIT_en && holds_msg) ? msg_d : '0;
    tx_busy_d = i_MBINIT_en && ((state_d != IDLE) || i_sb_busy) && !tx_owns;
    rx_busy_d = i_MBINIT_en && ((state_d != IDLE) || i_sb_busy) && !rx_owns;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q                <= IDLE;
      cnt_q                  <= '0;
      gnt_tx_q               <= 1'b0;
      msg_q                  <= '0;
      o_encoded_SB_msg       <= '0;
      o_msg_valid            <= 1'b0;
      o_tx_busy              <= 1'b1;
      o_rx_busy              <= 1'b1;
      o_tx_falling_edge_busy <= 1'b0;
      o_rx_falling_edge_busy <= 1'b0;
      o_timeout              <= 1'b0;
    end else begin
      state_q                <= state_d;
      cnt_q                  <= cnt_d;
      gnt_tx_q               <= gnt_tx_d;
      msg_q                  <= msg_d;
      o_encoded_SB_msg       <= enc_d;
      o_msg_valid            <= valid_d;
      o_tx_busy              <= tx_busy_d;
      o_rx_busy              <= rx_busy_d;
      o_tx_falling_edge_busy <= tx_fall_d;
      o_rx_falling_edge_busy <= rx_fall_d;
      o_timeout              <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mbinit_sb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mbinit_sb_arbiter
// Directed bench for mbinit_sb_arbiter. Inputs change on the falling clock
// edge and outputs are sampled there too, half a cycle after the rising
// edge that produced them.
// ---------------------------------------------------------------------------
module tb_mbinit_sb_arbiter;

  localparam int W  = 4;
  localparam int BT = 255;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_MBINIT_en;
  logic         i_tx_msg_valid;
  logic [W-1:0] i_tx_encoded_msg;
  logic         i_rx_msg_valid;
  logic [W-1:0] i_rx_encoded_msg;
  logic         i_sb_busy;
  logic [W-1:0] o_encoded_SB_msg;
  logic         o_msg_valid;
  logic         o_tx_busy;
  logic         o_rx_busy;
  logic         o_tx_falling_edge_busy;
  logic         o_rx_falling_edge_busy;
  logic         o_timeout;

  int checks = 0;
  int errors = 0;

  mbinit_sb_arbiter #(
    .SB_MSG_Width (W),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .i_MBINIT_en            (i_MBINIT_en),
    .i_tx_msg_valid         (i_tx_msg_valid),
    .i_tx_encoded_msg       (i_tx_encoded_msg),
    .i_rx_msg_valid         (i_rx_msg_valid),
    .i_rx_encoded_msg       (i_rx_encoded_msg),
    .i_sb_busy              (i_sb_busy),
    .o_encoded_SB_msg       (o_encoded_SB_msg),
    .o_msg_valid            (o_msg_valid),
    .o_tx_busy              (o_tx_busy),
    .o_rx_busy              (o_rx_busy),
    .o_tx_falling_edge_busy (o_tx_falling_edge_busy),
    .o_rx_falling_edge_busy (o_rx_falling_edge_busy),
    .o_timeout              (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // All outputs must show the values loaded while reset is asserted.
  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},   32'(o_msg_valid),            32'd0);
    check({tag, "_enc"},     32'(o_encoded_SB_msg),       32'd0);
    check({tag, "_txbusy"},  32'(o_tx_busy),              32'd1);
    check({tag, "_rxbusy"},  32'(o_rx_busy),              32'd1);
    check({tag, "_txfall"},  32'(o_tx_falling_edge_busy), 32'd0);
    check({tag, "_rxfall"},  32'(o_rx_falling_edge_busy), 32'd0);
    check({tag, "_timeout"}, 32'(o_timeout),              32'd0);
  endtask

  // One full transaction starting in IDLE with the requests already set.
  // Busy is high on (2 + wd_hold) consecutive sampling edges. Requester
  // messages are scrambled after the latch and restored at the end.
  task automatic do_txn(input string tag, input logic [W-1:0] exp_msg,
                        input logic exp_tx, input int wd_hold);
    tick();                                         // IDLE -> ISSUE
    check({tag, "_issue_valid"}, 32'(o_msg_valid),      32'd1);
    check({tag, "_issue_msg"},   32'(o_encoded_SB_msg), 32'(exp_msg));
    check({tag, "_issue_txbusy"}, 32'(o_tx_busy),       32'(!exp_tx));
    check({tag, "_issue_rxbusy"}, 32'(o_rx_busy),       32'(exp_tx));
    i_tx_encoded_msg = i_tx_encoded_msg ^ 4'hF;
    i_rx_encoded_msg = i_rx_encoded_msg ^ 4'hF;
    i_sb_busy = 1'b1;
    tick();                                         // ISSUE -> WAIT_BUSY
    check({tag, "_strobe_once"}, 32'(o_msg_valid), 32'd0);
    tick();                                         // WAIT_BUSY -> WAIT_DONE
    check({tag, "_wd_txbusy"}, 32'(o_tx_busy), 32'd1);
    check({tag, "_wd_rxbusy"}, 32'(o_rx_busy), 32'd1);
    repeat (wd_hold) tick();
    check({tag, "_hold_msg"}, 32'(o_encoded_SB_msg), 32'(exp_msg));
    check({tag, "_no_early_fall"},
          32'(o_tx_falling_edge_busy | o_rx_falling_edge_busy), 32'd0);
    i_sb_busy = 1'b0;
    tick();                                         // WAIT_DONE -> GAP
    check({tag, "_txfall"},  32'(o_tx_falling_edge_busy), 32'(exp_tx));
    check({tag, "_rxfall"},  32'(o_rx_falling_edge_busy), 32'(!exp_tx));
    check({tag, "_gap_msg"}, 32'(o_encoded_SB_msg),       32'd0);
    check({tag, "_gap_busy"}, 32'({o_tx_busy, o_rx_busy}), 32'd3);
    i_tx_encoded_msg = i_tx_encoded_msg ^ 4'hF;
    i_rx_encoded_msg = i_rx_encoded_msg ^ 4'hF;
    tick();                                         // GAP -> IDLE
    check({tag, "_idle_pulses"},
          32'(o_tx_falling_edge_busy | o_rx_falling_edge_busy), 32'd0);
    check({tag, "_idle_busy"}, 32'({o_tx_busy, o_rx_busy}), 32'd0);
    check({tag, "_idle_valid"}, 32'(o_msg_valid), 32'd0);
  endtask

  initial begin
    i_rst_n          = 1'b0;
    i_MBINIT_en      = 1'b1;
    i_tx_msg_valid   = 1'b0;
    i_tx_encoded_msg = '0;
    i_rx_msg_valid   = 1'b0;
    i_rx_encoded_msg = '0;
    i_sb_busy        = 1'b0;

    // Reset values.
    tick();
    tick();
    check_reset_values("rst");
    i_rst_n = 1'b1;

    // TX alone, busy high for 10 cycles.
    i_tx_msg_valid   = 1'b1;
    i_tx_encoded_msg = 4'b0001;
    do_txn("tx_alone", 4'b0001, 1'b1, 8);
    i_tx_msg_valid = 1'b0;
    tick();
    check("tx_alone_no_reissue", 32'(o_msg_valid), 32'd0);

    // Tie from reset: TX, then RX, then TX again.
    i_rst_n = 1'b0;
    tick();
    i_rst_n          = 1'b1;
    i_tx_msg_valid   = 1'b1;
    i_tx_encoded_msg = 4'b0001;
    i_rx_msg_valid   = 1'b1;
    i_rx_encoded_msg = 4'b0010;
    do_txn("tie1_tx", 4'b0001, 1'b1, 2);
    do_txn("tie2_rx", 4'b0010, 1'b0, 2);
    do_txn("tie3_tx", 4'b0001, 1'b1, 2);

    // Timeout on an RX grant; pointer is left at TX-last.
    i_tx_msg_valid = 1'b0;
    tick();                                         // IDLE -> ISSUE
    check("to_issue_msg", 32'(o_encoded_SB_msg), 32'd2);
    tick();                                         // enter WAIT_BUSY
    repeat (BT - 1) tick();
    check("to_not_yet", 32'(o_timeout), 32'd0);
    tick();                                         // BT cycles after entry
    check("to_pulse", 32'(o_timeout), 32'd1);
    check("to_no_fall",
          32'(o_tx_falling_edge_busy | o_rx_falling_edge_busy), 32'd0);
    check("to_msg_clear", 32'(o_encoded_SB_msg), 32'd0);
    tick();                                         // GAP -> IDLE
    check("to_pulse_once", 32'(o_timeout), 32'd0);
    // Pointer still says TX last, so the tie goes to RX.
    i_tx_msg_valid = 1'b1;
    do_txn("to_tie_rx", 4'b0010, 1'b0, 2);

    // Enable dropped in WAIT_DONE.
    i_rx_msg_valid = 1'b0;
    tick();                                         // IDLE -> ISSUE
    i_sb_busy = 1'b1;
    tick();                                         // -> WAIT_BUSY
    tick();                                         // -> WAIT_DONE
    i_MBINIT_en = 1'b0;
    tick();
    check("dis_valid",  32'(o_msg_valid),       32'd0);
    check("dis_msg",    32'(o_encoded_SB_msg),  32'd0);
    check("dis_busy",   32'({o_tx_busy, o_rx_busy}), 32'd0);
    check("dis_pulses", 32'({o_tx_falling_edge_busy, o_rx_falling_edge_busy,
                             o_timeout}), 32'd0);
    i_sb_busy = 1'b0;
    tick();
    check("dis_no_fall", 32'(o_tx_falling_edge_busy), 32'd0);
    check("dis_no_issue", 32'(o_msg_valid), 32'd0);
    i_MBINIT_en = 1'b1;
    do_txn("reen_tx", 4'b0001, 1'b1, 2);
    i_tx_msg_valid = 1'b0;

    // Foreign busy in IDLE blocks an RX grant.
    i_sb_busy        = 1'b1;
    i_rx_msg_valid   = 1'b1;
    i_rx_encoded_msg = 4'b0010;
    repeat (3) tick();
    check("blk_no_issue", 32'(o_msg_valid), 32'd0);
    check("blk_rxbusy",   32'(o_rx_busy),   32'd1);
    i_sb_busy = 1'b0;
    do_txn("blk_rx", 4'b0010, 1'b0, 2);
    i_rx_msg_valid = 1'b0;

    // Async reset during WAIT_BUSY.
    i_tx_msg_valid = 1'b1;
    tick();                                         // IDLE -> ISSUE
    tick();                                         // -> WAIT_BUSY
    check("ar_pre_msg",    32'(o_encoded_SB_msg), 32'd1);
    check("ar_pre_txbusy", 32'(o_tx_busy),        32'd0);
    i_rst_n = 1'b0;
    #1;
    check_reset_values("ar");
    i_tx_msg_valid = 1'b0;
    tick();
    check_reset_values("ar_hold");
    i_rst_n = 1'b1;
    // Pointer back at RX-last: the tie goes to TX.
    i_tx_msg_valid = 1'b1;
    i_rx_msg_valid = 1'b1;
    do_txn("ar_tie_tx", 4'b0001, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
